quad_encoder_counter: RTL and testbench

// - Consumes two debounced quadrature phases (a, b) from a rotary encoder and

---
 rtl/quad_encoder_counter.sv | 162 ++++++++++++++++
 tb/tb_quad_encoder_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder detent counter.
// Tracks the two debounced phases (a, b) of a rotary encoder, counts
// completed detents into an unsigned WIDTH-bit value, and emits one-cycle
// pulses for CW detents, CCW detents and illegal (both-phase) transitions.
// Build option: define ENCODER_WRAP_EN for modulo arithmetic on value;
// leave it undefined for saturating arithmetic.
module quad_encoder_counter #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 1,
    parameter int DETENT_TR = 4,
    parameter int INIT      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             err_pulse
);

    // Phase state encodings equal the sampled {a,b} pair.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } phase_t;

    // Four bits of signed accumulator comfortably hold -4..+4.
    localparam logic signed [3:0] ACC_POS = 4'(DETENT_TR);
    localparam logic signed [3:0] ACC_NEG = -ACC_POS;
    localparam logic [WIDTH-1:0]  INIT_V  = WIDTH'(INIT);

    phase_t            state;
    phase_t            state_next;
    logic signed [3:0] acc;
    logic signed [3:0] acc_next;
    logic signed [3:0] acc_inc;
    logic signed [3:0] acc_dec;
    logic [WIDTH-1:0]  value_next;
    logic [WIDTH-1:0]  value_up;
    logic [WIDTH-1:0]  value_down;
    logic              up_next;
    logic              down_next;
    logic              err_next;
    logic [1:0]        phase_in;
    logic              cw_step;
    logic              ccw_step;
    logic              illegal_step;

    assign phase_in = {a, b};
    assign acc_inc  = acc + 4'sd1;
    assign acc_dec  = acc - 4'sd1;

`ifdef ENCODER_WRAP_EN
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Modulo arithmetic: the carry/borrow simply falls off the top.
    always_comb begin
        value_up   = value + STEP_W;
        value_down = value - STEP_W;
    end
`else
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    logic [WIDTH:0] sum_x;
    logic [WIDTH:0] diff_x;

    // Saturating arithmetic: the extra top bit flags overflow or underflow.
    always_comb begin
        sum_x      = {1'b0, value} + STEP_X;
        diff_x     = {1'b0, value} - STEP_X;
        value_up   = sum_x[WIDTH]  ? {WIDTH{1'b1}} : sum_x[WIDTH-1:0];
        value_down = diff_x[WIDTH] ? {WIDTH{1'b0}} : diff_x[WIDTH-1:0];
    end
`endif

    // Classify the move from the last sampled phase pair to the current one.
    always_comb begin
        cw_step  = 1'b0;
        ccw_step = 1'b0;
        unique case (state)
            S00: begin
                cw_step  = (phase_in == 2'b01);
                ccw_step = (phase_in == 2'b10);
            end
            S01: begin
                cw_step  = (phase_in == 2'b11);
                ccw_step = (phase_in == 2'b00);
            end
            S11: begin
                cw_step  = (phase_in == 2'b10);
                ccw_step = (phase_in == 2'b01);
            end
            S10: begin
                cw_step  = (phase_in == 2'b00);
                ccw_step = (phase_in == 2'b11);
            end
            default: ;
        endcase
        illegal_step = (phase_in == ~state);
    end

    // Next phase state, accumulator, value and pulses; load overrides value.
    always_comb begin
        state_next = phase_t'(phase_in);
        acc_next   = acc;
        value_next = value;
        up_next    = 1'b0;
        down_next  = 1'b0;
        err_next   = 1'b0;

        if (illegal_step) begin
            err_next = 1'b1;
            acc_next = 4'sd0;
        end else if (cw_step) begin
            if (acc_inc == ACC_POS) begin
                up_next    = 1'b1;
                value_next = value_up;
                acc_next   = 4'sd0;
            end else begin
                acc_next = acc_inc;
            end
        end else if (ccw_step) begin
            if (acc_dec == ACC_NEG) begin
                down_next  = 1'b1;
                value_next = value_down;
                acc_next   = 4'sd0;
            end else begin
                acc_next = acc_dec;
            end
        end

        if (load) begin
            value_next = load_value;
            acc_next   = 4'sd0;
        end
    end

    // State register; reset adopts the live phases so it never counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= phase_t'(phase_in);
            acc        <= 4'sd0;
            value      <= INIT_V;
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            value      <= value_next;
            up_pulse   <= up_next;
            down_pulse <= down_next;
            err_pulse  <= err_next;
        end
    end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed testbench for quad_encoder_counter (default parameters).
// Expected values follow the ENCODER_WRAP_EN macro if it is defined.
module tb_quad_encoder_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic [7:0] value;
    logic       up_pulse;
    logic       down_pulse;
    logic       err_pulse;

    int test_count = 0;
    int fail_count = 0;

    quad_encoder_counter dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .load       (load),
        .load_value (load_value),
        .value      (value),
        .up_pulse   (up_pulse),
        .down_pulse (down_pulse),
        .err_pulse  (err_pulse)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Compares all outputs plus the pulse exclusivity rule.
    task automatic expectOutputs(input string tag, input logic [7:0] exp_value,
                                 input logic exp_up, input logic exp_down,
                                 input logic exp_err);
        checkOutput({tag, ".value"}, 32'(value), 32'(exp_value));
        checkOutput({tag, ".up"},    32'(up_pulse), 32'(exp_up));
        checkOutput({tag, ".down"},  32'(down_pulse), 32'(exp_down));
        checkOutput({tag, ".err"},   32'(err_pulse), 32'(exp_err));
        checkOutput({tag, ".onehot"},
                    32'($countones({up_pulse, down_pulse, err_pulse}) <= 1), 32'd1);
    endtask

    // Drive inputs on the falling edge, then settle just after the rising edge.
    task automatic applyStimulus(input logic na, input logic nb,
                                 input logic nload, input logic [7:0] nlv);
        @(negedge clk);
        a          = na;
        b          = nb;
        load       = nload;
        load_value = nlv;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic na, input logic nb);
        @(negedge clk);
        reset = 1'b1;
        a     = na;
        b     = nb;
        load  = 1'b0;
        @(posedge clk);
        #1;
        expectOutputs("reset", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [7:0] exp_sat_hi;
    logic [7:0] exp_sat_lo;

    initial begin
`ifdef ENCODER_WRAP_EN
        exp_sat_hi = 8'd0;
        exp_sat_lo = 8'd255;
`else
        exp_sat_hi = 8'd255;
        exp_sat_lo = 8'd0;
`endif

        // Reset with phases at 11 and hold: nothing may count.
        doReset(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
            expectOutputs("hold11", 8'd0, 1'b0, 1'b0, 1'b0);
        end

        // Full CW detent from 00: pulse only on the fourth transition.
        doReset(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        expectOutputs("cw1", 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        expectOutputs("cw2", 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        expectOutputs("cw3", 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        expectOutputs("cw4", 8'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        expectOutputs("cwhold", 8'd1, 1'b0, 1'b0, 1'b0);

        // Load 5, then a full CCW detent.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd5);
        expectOutputs("load5", 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        expectOutputs("ccw1", 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        expectOutputs("ccw2", 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        expectOutputs("ccw3", 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        expectOutputs("ccw4", 8'd4, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        expectOutputs("ccwhold", 8'd4, 1'b0, 1'b0, 1'b0);

        // Reversal mid-detent, then a full CW detent needs exactly four steps.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        expectOutputs("rev1", 8'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        expectOutputs("rev2", 8'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        expectOutputs("revcw1", 8'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        expectOutputs("revcw2", 8'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        expectOutputs("revcw3", 8'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        expectOutputs("revcw4", 8'd5, 1'b1, 1'b0, 1'b0);

        // Illegal jump 00->11, then a full CW detent from 11.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        expectOutputs("illegal", 8'd5, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        expectOutputs("illhold", 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        expectOutputs("errcw1", 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        expectOutputs("errcw2", 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        expectOutputs("errcw3", 8'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        expectOutputs("errcw4", 8'd6, 1'b1, 1'b0, 1'b0);

        // Upper limit: load 255 then one CW detent from 11.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd255);
        expectOutputs("load255", 8'd255, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        expectOutputs("hipre", 8'd255, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        expectOutputs("hilimit", exp_sat_hi, 1'b1, 1'b0, 1'b0);

        // Lower limit: load 0 then one CCW detent from 11.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd0);
        expectOutputs("load0", 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        expectOutputs("lopre", 8'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        expectOutputs("lolimit", exp_sat_lo, 1'b0, 1'b1, 1'b0);

        // Load coinciding with a completing CW detent: load wins, pulse stays.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd10);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
        expectOutputs("ldpre", 8'd10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h80);
        expectOutputs("lddetent", 8'h80, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        expectOutputs("ldhold", 8'h80, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
